// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: walks a KxK window over a single-channel feature map in
// raster order, emitting tap addresses and the convolve-stage control strobes,
// and captures one saturated result per window with its output-map index.
// Optional build macro: CONV_CTRL_RELU_EN clamps negative results to zero
// before they are captured; timing is the same in both builds.
module conv_window_ctrl #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 5,
  parameter int ADDR_W    = 10,
  parameter int WADDR_W   = 5,
  parameter int SAT_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        sig_addr,
  output logic [WADDR_W-1:0]       wgt_addr,
  output logic                     rd_en,
  output logic                     clken,
  output logic                     s_convout,
  output logic                     en_sat,
  output logic                     en_mult_r,
  input  logic signed [7:0]        convout,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic signed [7:0]        out_data
);

  localparam int DATA_W = 8;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int NWIN   = OUT_W * OUT_H;
  localparam int KC_W   = $clog2(K + 1);
  localparam int OC_W   = $clog2(((OUT_W > OUT_H) ? OUT_W : OUT_H) + 1);

  localparam logic [KC_W-1:0]   K_LAST    = KC_W'(K - 1);
  localparam logic [OC_W-1:0]   OX_LAST   = OC_W'(OUT_W - 1);
  localparam logic [OC_W-1:0]   OY_LAST   = OC_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  // Moving from the last column of one output row to the first column of the
  // next advances the window origin by IMG_W - OUT_W + 1 = K pixels.
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] LAST_OUT  = ADDR_W'(NWIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [KC_W-1:0]           kx_q, kx_d, ky_q, ky_d;
  logic [OC_W-1:0]           ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0]         win_base_q, win_base_d;
  logic [ADDR_W-1:0]         row_base_q, row_base_d;
  logic [ADDR_W-1:0]         sig_addr_q, sig_addr_d;
  logic [WADDR_W-1:0]        wgt_addr_q, wgt_addr_d;
  logic                      rd_en_q, rd_en_d;
  logic                      clken_q, clken_d;
  logic                      s_convout_q, s_convout_d;
  logic [SAT_DELAY-1:0]      sat_pipe_q, sat_pipe_d;
  logic                      out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]         win_cnt_q, win_cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic tap_last;
  logic win_last;

  // Optional rectification of the captured result.
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef CONV_CTRL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign tap_last = (kx_q == K_LAST) && (ky_q == K_LAST);
  assign win_last = (ox_q == OX_LAST) && (oy_q == OY_LAST);

  // Next-state logic: FSM, incremental address counters and strobe delay line.
  always_comb begin
    state_d     = state_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    win_base_d  = win_base_q;
    row_base_d  = row_base_q;
    sig_addr_d  = sig_addr_q;
    wgt_addr_d  = wgt_addr_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    win_cnt_d   = win_cnt_q;

    // Stage 1: RAM data arrives one cycle after the read strobe.
    clken_d     = rd_en_q;
    s_convout_d = rd_en_q & tap_last;

    // Stage 2: convolve saturation latency.
    sat_pipe_d    = '0;
    sat_pipe_d[0] = s_convout_q;
    for (int i = 1; i < SAT_DELAY; i++) begin
      sat_pipe_d[i] = sat_pipe_q[i-1];
    end

    // Stage 3: convout is valid during the en_sat cycle; capture it.
    out_valid_d = en_sat;
    if (en_sat) begin
      out_data_d = relu(convout);
      out_addr_d = win_cnt_q;
      win_cnt_d  = win_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          kx_d       = '0;
          ky_d       = '0;
          ox_d       = '0;
          oy_d       = '0;
          win_base_d = '0;
          row_base_d = '0;
          sig_addr_d = '0;
          wgt_addr_d = '0;
        end
      end
      S_RUN: begin
        if (kx_q != K_LAST) begin
          kx_d       = kx_q + 1'b1;
          sig_addr_d = sig_addr_q + 1'b1;
          wgt_addr_d = wgt_addr_q + 1'b1;
        end else if (ky_q != K_LAST) begin
          kx_d       = '0;
          ky_d       = ky_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
          sig_addr_d = row_base_q + ROW_STEP;
          wgt_addr_d = wgt_addr_q + 1'b1;
        end else begin
          kx_d       = '0;
          ky_d       = '0;
          wgt_addr_d = '0;
          if (win_last) begin
            state_d    = S_DRAIN;
            rd_en_d    = 1'b0;
            ox_d       = '0;
            oy_d       = '0;
            win_base_d = '0;
            row_base_d = '0;
            sig_addr_d = '0;
          end else if (ox_q != OX_LAST) begin
            ox_d       = ox_q + 1'b1;
            win_base_d = win_base_q + 1'b1;
            row_base_d = win_base_q + 1'b1;
            sig_addr_d = win_base_q + 1'b1;
          end else begin
            ox_d       = '0;
            oy_d       = oy_q + 1'b1;
            win_base_d = win_base_q + WRAP_STEP;
            row_base_d = win_base_q + WRAP_STEP;
            sig_addr_d = win_base_q + WRAP_STEP;
          end
        end
      end
      S_DRAIN: begin
        if (out_valid_q && (out_addr_q == LAST_OUT)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        win_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      win_base_q  <= '0;
      row_base_q  <= '0;
      sig_addr_q  <= '0;
      wgt_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      clken_q     <= 1'b0;
      s_convout_q <= 1'b0;
      sat_pipe_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      win_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      win_base_q  <= win_base_d;
      row_base_q  <= row_base_d;
      sig_addr_q  <= sig_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      rd_en_q     <= rd_en_d;
      clken_q     <= clken_d;
      s_convout_q <= s_convout_d;
      sat_pipe_q  <= sat_pipe_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      win_cnt_q   <= win_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign en_mult_r = busy_q;
  assign done      = done_q;
  assign sig_addr  = sig_addr_q;
  assign wgt_addr  = wgt_addr_q;
  assign rd_en     = rd_en_q;
  assign clken     = clken_q;
  assign s_convout = s_convout_q;
  assign en_sat    = sat_pipe_q[SAT_DELAY-1];
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: a 4x4/K=2 instance for cycle-exact
// sequencing checks and a default 28x28/K=5 instance for the full-size run.
module tb_conv_window_ctrl;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, start_b;
  logic signed [7:0] convout, convout_b;

  logic              busy, done, rd_en, clken, s_convout, en_sat, en_mult_r, out_valid;
  logic [9:0]        sig_addr, out_addr;
  logic [4:0]        wgt_addr;
  logic signed [7:0] out_data;

  logic              busy_b, done_b, rd_en_b, clken_b, s_convout_b, en_sat_b, en_mult_r_b, out_valid_b;
  logic [9:0]        sig_addr_b, out_addr_b;
  logic [4:0]        wgt_addr_b;
  logic signed [7:0] out_data_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(2), .ADDR_W(10), .WADDR_W(5), .SAT_DELAY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .sig_addr(sig_addr), .wgt_addr(wgt_addr), .rd_en(rd_en), .clken(clken),
    .s_convout(s_convout), .en_sat(en_sat), .en_mult_r(en_mult_r), .convout(convout),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
  );

  conv_window_ctrl dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .sig_addr(sig_addr_b), .wgt_addr(wgt_addr_b), .rd_en(rd_en_b), .clken(clken_b),
    .s_convout(s_convout_b), .en_sat(en_sat_b), .en_mult_r(en_mult_r_b), .convout(convout_b),
    .out_valid(out_valid_b), .out_addr(out_addr_b), .out_data(out_data_b)
  );

  function automatic logic signed [7:0] exp_relu(input logic signed [7:0] x);
`ifdef CONV_CTRL_RELU_EN
    return (x < 0) ? 8'sd0 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start_b = 1'b0; convout = 8'sd0; convout_b = 8'sd0;
    tick; tick;
    checks++;
    if ({busy, done, rd_en, clken, s_convout, en_sat, en_mult_r, out_valid} !== 8'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000000",
               {busy, done, rd_en, clken, s_convout, en_sat, en_mult_r, out_valid});
    end
    checks++;
    if (sig_addr !== 10'd0 || wgt_addr !== 5'd0 || out_addr !== 10'd0 || out_data !== 8'sd0) begin
      failures++;
      $display("FAIL reset_data got sig=%0d wgt=%0d oaddr=%0d odata=%0d exp all 0",
               sig_addr, wgt_addr, out_addr, out_data);
    end
    checks++;
    if ({busy_b, done_b, rd_en_b, out_valid_b, sig_addr_b} !== 14'd0) begin
      failures++;
      $display("FAIL reset_big got=%h exp=0", {busy_b, done_b, rd_en_b, out_valid_b, sig_addr_b});
    end
    reset = 1'b0;
    tick;
  endtask

  // Cycle-exact strobe timing for one whole map with convout = -3.
  task automatic test_full_map;
    logic e_rd, e_ck, e_sc, e_es, e_ov, e_busy, e_done;
    int   rd_cnt = 0;
    convout = -8'sd3;
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick;
      if (k == 1) start = 1'b0;
      e_rd   = (k >= 1 && k <= 36);
      e_ck   = (k >= 2 && k <= 37);
      e_sc   = (k >= 5 && k <= 37 && (k - 5) % 4 == 0);
      e_es   = (k >= 7 && k <= 39 && (k - 7) % 4 == 0);
      e_ov   = (k >= 8 && k <= 40 && (k - 8) % 4 == 0);
      e_busy = (k <= 41);
      e_done = (k == 41);
      if (rd_en === 1'b1) rd_cnt++;
      checks++;
      if (rd_en !== e_rd) begin failures++; $display("FAIL map_rd_en cyc=%0d got=%b exp=%b", k, rd_en, e_rd); end
      checks++;
      if (clken !== e_ck) begin failures++; $display("FAIL map_clken cyc=%0d got=%b exp=%b", k, clken, e_ck); end
      checks++;
      if (s_convout !== e_sc) begin failures++; $display("FAIL map_s_convout cyc=%0d got=%b exp=%b", k, s_convout, e_sc); end
      checks++;
      if (en_sat !== e_es) begin failures++; $display("FAIL map_en_sat cyc=%0d got=%b exp=%b", k, en_sat, e_es); end
      checks++;
      if (out_valid !== e_ov) begin failures++; $display("FAIL map_out_valid cyc=%0d got=%b exp=%b", k, out_valid, e_ov); end
      if (e_ov) begin
        checks++;
        if (out_addr !== 10'((k - 8) / 4) || out_data !== exp_relu(-8'sd3)) begin
          failures++;
          $display("FAIL map_result cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                   k, out_addr, out_data, (k - 8) / 4, exp_relu(-8'sd3));
        end
      end
      checks++;
      if (busy !== e_busy || en_mult_r !== e_busy) begin
        failures++; $display("FAIL map_busy cyc=%0d got busy=%b mult_r=%b exp=%b", k, busy, en_mult_r, e_busy);
      end
      checks++;
      if (done !== e_done) begin failures++; $display("FAIL map_done cyc=%0d got=%b exp=%b", k, done, e_done); end
    end
    checks++;
    if (rd_cnt != 36) begin failures++; $display("FAIL map_rd_count got=%0d exp=36", rd_cnt); end
  endtask

  // Tap address stream against a direct (multiplying) model plus the
  // hand-computed window-4 vector.
  task automatic test_window_addr;
    int w4_sig [4] = '{5, 6, 9, 10};
    int w, tap, ox, oy, kx, ky, es, ew;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick;
      if (k == 1) start = 1'b0;
      if (k <= 36) begin
        w = (k - 1) / 4; tap = (k - 1) % 4;
        ox = w % 3; oy = w / 3; kx = tap % 2; ky = tap / 2;
        es = (oy + ky) * 4 + ox + kx;
        ew = ky * 2 + kx;
        checks++;
        if (sig_addr !== 10'(es) || wgt_addr !== 5'(ew)) begin
          failures++;
          $display("FAIL addr_stream cyc=%0d got sig=%0d wgt=%0d exp sig=%0d wgt=%0d", k, sig_addr, wgt_addr, es, ew);
        end
        if (w == 4) begin
          checks++;
          if (sig_addr !== 10'(w4_sig[tap]) || wgt_addr !== 5'(tap)) begin
            failures++;
            $display("FAIL addr_win4 tap=%0d got sig=%0d wgt=%0d exp sig=%0d wgt=%0d",
                     tap, sig_addr, wgt_addr, w4_sig[tap], tap);
          end
        end
      end
    end
  endtask

  // Per-window results; convout is only meaningful in the en_sat cycle.
  task automatic test_data_values;
    logic signed [7:0] vals [9] = '{-8'sd3, 8'sd37, -8'sd128, 8'sd127, 8'sd0, -8'sd1, 8'sd5, 8'sd100, -8'sd50};
    int n_es = 0;
    int n_ov = 0;
    start = 1'b1;
    convout = 8'sh55;
    for (int k = 1; k <= 45; k++) begin
      tick;
      if (k == 1) start = 1'b0;
      if (out_valid === 1'b1) begin
        checks++;
        if (n_ov >= 9 || out_data !== exp_relu(vals[n_ov % 9]) || out_addr !== 10'(n_ov)) begin
          failures++;
          $display("FAIL data_value n=%0d got data=%h addr=%0d exp data=%h addr=%0d",
                   n_ov, out_data, out_addr, exp_relu(vals[n_ov % 9]), n_ov);
        end
        n_ov++;
      end
      convout = 8'sh55;
      if (en_sat === 1'b1 && n_es < 9) begin
        convout = vals[n_es];
        n_es++;
      end
    end
    checks++;
    if (n_ov != 9) begin failures++; $display("FAIL data_count got=%0d exp=9", n_ov); end
    convout = 8'sd0;
  endtask

  // start re-pulsed mid-RUN and in the DONE cycle must both be ignored.
  task automatic test_start_midrun;
    int rd_cnt = 0, ov_cnt = 0, done_at = -1;
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick;
      if (rd_en === 1'b1) rd_cnt++;
      if (out_valid === 1'b1) ov_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 11) begin
        checks++;
        if (sig_addr !== 10'd6 || wgt_addr !== 5'd2) begin
          failures++; $display("FAIL midrun_addr got sig=%0d wgt=%0d exp sig=6 wgt=2", sig_addr, wgt_addr);
        end
      end
      if (k >= 42) begin
        checks++;
        if (rd_en !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL done_start_dropped cyc=%0d got rd_en=%b busy=%b exp 0 0", k, rd_en, busy);
        end
      end
      start = (k == 10 || k == 20 || k == 41);
    end
    start = 1'b0;
    checks++;
    if (rd_cnt != 36 || ov_cnt != 9) begin
      failures++; $display("FAIL midrun_counts got rd=%0d ov=%0d exp rd=36 ov=9", rd_cnt, ov_cnt);
    end
    checks++;
    if (done_at != 41) begin failures++; $display("FAIL midrun_done got=%0d exp=41", done_at); end
  endtask

  // Reset inside window 3 discards everything; a fresh start begins at 0.
  task automatic test_reset_midrun;
    int ov_cnt = 0, first_ov = -1, done_at = -1;
    start = 1'b1;
    convout = 8'sd9;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (k == 1) start = 1'b0;
      if (out_valid === 1'b1) ov_cnt++;
    end
    reset = 1'b1;
    tick;
    checks++;
    if ({busy, done, rd_en, clken, s_convout, en_sat, en_mult_r, out_valid} !== 8'b0 ||
        sig_addr !== 10'd0 || wgt_addr !== 5'd0 || out_addr !== 10'd0 || out_data !== 8'sd0) begin
      failures++;
      $display("FAIL midreset_clear got strobes=%b sig=%0d wgt=%0d oaddr=%0d odata=%0d exp all 0",
               {busy, done, rd_en, clken, s_convout, en_sat, en_mult_r, out_valid},
               sig_addr, wgt_addr, out_addr, out_data);
    end
    checks++;
    if (ov_cnt != 2) begin failures++; $display("FAIL midreset_before got=%0d exp=2", ov_cnt); end
    reset = 1'b0;
    for (int k = 16; k <= 45; k++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0 || rd_en !== 1'b0) begin
        failures++; $display("FAIL midreset_quiet cyc=%0d got ov=%b rd=%b exp 0 0", k, out_valid, rd_en);
      end
    end
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick;
      if (k == 1) start = 1'b0;
      if (out_valid === 1'b1 && first_ov < 0) begin
        first_ov = k;
        checks++;
        if (out_addr !== 10'd0 || out_data !== 8'sd9) begin
          failures++; $display("FAIL restart_first got addr=%0d data=%0d exp addr=0 data=9", out_addr, out_data);
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    checks++;
    if (first_ov != 8 || done_at != 41) begin
      failures++; $display("FAIL restart_timing got first_ov=%0d done=%0d exp 8 41", first_ov, done_at);
    end
  endtask

  // Default 28x28, K=5 instance end to end.
  task automatic test_big;
    int ov_cnt = 0, done_at = -1;
    convout_b = -8'sd3;
    start_b = 1'b1;
    for (int k = 1; k <= 14500; k++) begin
      tick;
      if (k == 1) start_b = 1'b0;
      if (out_valid_b === 1'b1) begin
        checks++;
        if (out_addr_b !== 10'(ov_cnt) || out_data_b !== exp_relu(-8'sd3)) begin
          failures++;
          $display("FAIL big_result n=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                   ov_cnt, out_addr_b, out_data_b, ov_cnt, exp_relu(-8'sd3));
        end
        ov_cnt++;
      end
      if (done_b === 1'b1 && done_at < 0) done_at = k;
      if (done_at >= 0 && k > done_at + 1) break;
    end
    checks++;
    if (ov_cnt != 576) begin failures++; $display("FAIL big_count got=%0d exp=576", ov_cnt); end
    checks++;
    if (done_at != 14405) begin failures++; $display("FAIL big_done got=%0d exp=14405", done_at); end
    checks++;
    if (busy_b !== 1'b0) begin failures++; $display("FAIL big_busy_after got=%b exp=0", busy_b); end
  endtask

  initial begin
    test_reset;
    test_full_map;
    test_window_addr;
    test_data_values;
    test_start_midrun;
    test_reset_midrun;
    test_big;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer placed directly upstream of the convolve MAC/saturation stage. For every valid output position it walks a K×K window over a single-channel feature map held in an external synchronous RAM. It emits tap addresses, drives the convolve control strobes (`clken`, `s_convout`, `en_sat`, `en_mult_r`) and captures each saturated `convout` result together with its output-map address. One `start` pulse processes a whole map, using a continuous back-to-back tap stream with no bubbles between windows.

## Interface
- `IMG_W`, 28: input map width in pixels.
- `IMG_H`, 28: input map height in pixels.
- `K`, 5: kernel edge; each window has K*K taps.
- `ADDR_W`, 10: signal and output address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `WADDR_W`, 5: weight address width; must satisfy 2^WADDR_W ≥ K*K.
- `SAT_DELAY`, 2: cycles from a `s_convout` cycle to the matching `en_sat` cycle.

Ports (clock and reset first):
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request to process the map; ignored while `busy`.
- `busy`  out  1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1: one-cycle pulse after the last result has been captured.
- `sig_addr`  out  ADDR_W: feature-RAM read address.
- `wgt_addr`  out  WADDR_W: weight-RAM read address.
- `rd_en`  out  1: RAM read strobe. Both RAMs have 1-cycle read latency.
- `clken`  out  1: MAC enable, high while tap data is valid on the MAC inputs.
- `s_convout`  out  1: high with the last tap of each window.
- `en_sat`  out  1: saturation/register strobe for the convolve stage.
- `en_mult_r`  out  1: held high while `busy`.
- `convout`  in  8: signed result from the convolve stage.
- `out_valid`  out  1: one-cycle strobe that `out_data`/`out_addr` are new.
- `out_addr`  out  ADDR_W: output index oy*OUT_W+ox.
- `out_data`  out  8: captured signed result.

## Operation
- OUT_W = IMG_W−K+1 and OUT_H = IMG_H−K+1. Windows are processed in raster order: ox fastest, then oy. Within a window, taps run kx fastest, then ky.
- Address for each tap:
  - `sig_addr` = (oy+ky)*IMG_W + (ox+kx).
  - `wgt_addr` = ky*K + kx.
  - Both are computed incrementally with counters; no multiplier is used.
- FSM states:
  - IDLE: `start` moves to RUN.
  - RUN: one tap address per cycle with `rd_en`=1. After the last tap of the last window, moves to DRAIN.
  - DRAIN: waits until the last result has been captured, then moves to DONE.
  - DONE: lasts one cycle, asserts `done`, then returns to IDLE.
- Control pipeline (delay registers from `rd_en`):
  - `clken` = `rd_en` delayed 1 cycle.
  - `s_convout` = last-tap flag delayed 1 cycle, qualified by `clken`.
  - `en_sat` = `s_convout` delayed SAT_DELAY cycles.
  - `out_valid` = `en_sat` delayed 1 cycle. On that cycle `convout` is sampled into `out_data`.
- A window-index FIFO-less counter tracks `out_addr`. It increments on each `out_valid` and wraps to 0 at IDLE entry.
- `start` during IDLE or DONE is accepted only in IDLE; in DONE it is dropped.
- Reset at any point, including mid-RUN or mid-DRAIN:
  - Next state is IDLE.
  - All counters and delay registers are cleared.
  - In-flight results are discarded.

## Timing
- Reset values: every output is 0.
- `start` is sampled at cycle t. Then:
  - First `rd_en` occurs at t+1.
  - First `clken` occurs at t+2.
  - First `s_convout` occurs at t+1+K*K.
- Window n (0-based) has its `s_convout` at t+(n+1)*K*K+1, its `en_sat` SAT_DELAY cycles later, and its `out_valid` one cycle after that.
- Throughput is one result per K*K cycles, sustained.
- `done` occurs at t + OUT_W*OUT_H*K*K + SAT_DELAY + 3. `busy` falls the cycle after `done`.

## Configuration
- `CONV_CTRL_RELU_EN` defined: `out_data` = 0 when `convout` is negative, otherwise `convout`.
- `CONV_CTRL_RELU_EN` undefined: `out_data` = `convout` unchanged.
- Timing is identical in both builds.

## Test plan
- IMG_W=IMG_H=4, K=2, SAT_DELAY=2, `start` pulse → exactly 36 `rd_en` cycles, 9 `s_convout` pulses spaced 4 cycles apart, 9 `out_valid` with `out_addr` 0..8, and `done` at t+41.
- Same config, check address stream for window 4 (ox=1, oy=1) → `sig_addr` 5, 6, 9, 10 and `wgt_addr` 0, 1, 2, 3.
- Bench model returns `convout`=−3 for every window → `out_data`=0xFD without the macro, 0x00 with `CONV_CTRL_RELU_EN`.
- `start` reasserted mid-RUN → ignored; the sequence and `done` timing are unchanged.
- `reset` asserted during window 3 → all outputs 0 next cycle, no further `out_valid`. A fresh `start` restarts from `out_addr` 0.
- Default 28×28, K=5 → 576 results, `done` exactly 14405 cycles after `start`.
